// File: rtl/i281_pkg.sv
// Shared encodings and default widths for the i281 run/step sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i281_pkg;

  localparam int PC_W_DEF  = 6;   // 64-entry code memory
  localparam int CNT_W_DEF = 16;  // run-cycle counter / budget width

  // Sequencer state encodings (also driven out on the state port)
  localparam logic [1:0] RC_IDLE = 2'd0;
  localparam logic [1:0] RC_RUN  = 2'd1;
  localparam logic [1:0] RC_STEP = 2'd2;
  localparam logic [1:0] RC_HALT = 2'd3;

  // Halt cause encodings
  localparam logic [1:0] HC_NONE  = 2'd0;
  localparam logic [1:0] HC_STOP  = 2'd1;
  localparam logic [1:0] HC_BP    = 2'd2;
  localparam logic [1:0] HC_LIMIT = 2'd3;

  // RUN and STEP are the two states in which the CPU may be enabled
  function automatic logic is_active(input logic [1:0] st);
    return (st == RC_RUN) || (st == RC_STEP);
  endfunction

endpackage

// File: rtl/i281_run_ctrl_if.sv
// Control/status bundle between board inputs, CPU and the run sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a (level and pulse signals, no handshake).
// master: board/CPU side drives requests, pc and breakpoint setup.
// slave : the sequencer consumes them and drives run/state/cause/count.
interface i281_run_ctrl_if #(
  parameter int PC_W  = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             step;
  logic             clear;
  logic             instr_done;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic [CNT_W-1:0] cycle_limit;
  logic             run;
  logic [1:0]       state;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, stop, step, clear, instr_done, pc, bp_addr, bp_valid, cycle_limit,
    input  run, state, halt_cause, cycle_count
  );

  modport slave (
    input  start, stop, step, clear, instr_done, pc, bp_addr, bp_valid, cycle_limit,
    output run, state, halt_cause, cycle_count
  );
endinterface

// File: rtl/i281_edge_detect.sv
// Registered rising-edge detector for a pushbutton level.
// Latency: pulse is combinational in the cycle the level first reads high.
// Backpressure: none; a held level yields exactly one pulse.
// Ports: clk_i, rst_ni (async active-low), d_i level in, rise_o pulse out.
module i281_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/i281_run_ctrl.sv
// Run/step sequencer producing the single i281 CPU run enable.
// Latency: requests registered at one edge, run follows next cycle; breakpoint drops run same cycle.
// Backpressure: none; start/step ignored while running, stop ignored while idle/halted.
// Ports: clock, reset (async active-low), bus (slave modport of i281_run_ctrl_if).
// Build option: define I281_RUN_CTRL_BREAKPOINT_EN to include the PC breakpoint.
module i281_run_ctrl
  import i281_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clock,
  input logic           reset,
  i281_run_ctrl_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             step_pulse;
  logic             active;
  logic             bp_hit;
  logic             run;
  logic             limit_hit;

  i281_edge_detect u_step_edge (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (bus.step),
    .rise_o (step_pulse)
  );

  assign active = is_active(state_q);

`ifdef I281_RUN_CTRL_BREAKPOINT_EN
  // skip_q masks the compare for the first cycle after entering RUN/STEP so
  // that resuming at the breakpoint PC lets that instruction execute once.
  logic skip_q, skip_d;

  assign bp_hit = bus.bp_valid & (bus.pc == bus.bp_addr) & ~skip_q & active;
  assign skip_d = is_active(state_d) & ~active;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_valid};
`endif

  // Combinational so a breakpoint blocks the matching instruction immediately
  assign run = active & ~bp_hit;

  // One bit wider so the budget compare still works once the counter saturates
  assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign limit_hit = (bus.cycle_limit != '0) & run & (cnt_inc >= {1'b0, bus.cycle_limit});

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;

    if (run && !(&cnt_q)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end

    if (bus.clear) begin
      state_d = RC_IDLE;
      cause_d = HC_NONE;
      cnt_d   = '0;
    end else if (bus.stop && active) begin
      state_d = RC_HALT;
      cause_d = HC_STOP;
    end else if (bp_hit) begin
      state_d = RC_HALT;
      cause_d = HC_BP;
    end else if (limit_hit) begin
      state_d = RC_HALT;
      cause_d = HC_LIMIT;
    end else if ((state_q == RC_STEP) && bus.instr_done && run) begin
      state_d = RC_HALT;
      cause_d = HC_NONE;
    end else if (!active && bus.start) begin
      state_d = RC_RUN;
      cause_d = HC_NONE;
    end else if (!active && step_pulse) begin
      state_d = RC_STEP;
      cause_d = HC_NONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RC_IDLE;
      cause_q <= HC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.run         = run;
  assign bus.state       = state_q;
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_i281_run_ctrl.sv
// Self-checking bench for i281_run_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model; a small CPU stand-in advances pc.
// Counter width is reduced to 8 bits so saturation is reachable quickly.
module tb_i281_run_ctrl;
  import i281_pkg::*;

  localparam int PC_W  = 6;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  i281_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  i281_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int run_hi = 0;

  // Model: mode 0 idle, 1 run, 2 step, 3 halt; age = cycles spent since entering run/step
  int m_st, m_cause, m_cnt, m_age;
  bit m_prev_step, last_run;

  // CPU stand-in
  logic [PC_W-1:0] cpu_pc;
  int cpu_ic, cpu_len;
  bit rand_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_bp();
`ifdef I281_RUN_CTRL_BREAKPOINT_EN
    return bus.bp_valid && (bus.pc == bus.bp_addr) && (m_age > 0) && (m_st == 1 || m_st == 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_run();
    return (m_st == 1 || m_st == 2) && !m_bp();
  endfunction

  task automatic model_reset();
    m_st = 0; m_cause = 0; m_cnt = 0; m_age = 0; m_prev_step = 0; last_run = 0;
  endtask

  task automatic model_step();
    bit r, bp, act, sp, lim;
    int nst, nca, ncnt;
    r   = m_run();
    bp  = m_bp();
    act = (m_st == 1 || m_st == 2);
    sp  = bus.step && !m_prev_step;
    lim = (bus.cycle_limit != 0) && r && ((m_cnt + 1) >= int'(bus.cycle_limit));
    nst = m_st; nca = m_cause; ncnt = m_cnt;
    if (r && m_cnt < CMAX) ncnt = m_cnt + 1;
    if (bus.clear)                                begin nst = 0; nca = 0; ncnt = 0; end
    else if (bus.stop && act)                     begin nst = 3; nca = 1; end
    else if (bp)                                  begin nst = 3; nca = 2; end
    else if (lim)                                 begin nst = 3; nca = 3; end
    else if (m_st == 2 && bus.instr_done && r)    begin nst = 3; nca = 0; end
    else if (!act && bus.start)                   begin nst = 1; nca = 0; end
    else if (!act && sp)                          begin nst = 2; nca = 0; end
    if (nst == 1 || nst == 2) m_age = act ? m_age + 1 : 0;
    else m_age = 0;
    m_st = nst; m_cause = nca; m_cnt = ncnt;
    m_prev_step = bus.step;
    last_run = r;
  endtask

  task automatic cpu_drive();
    bus.pc         = cpu_pc;
    bus.instr_done = (cpu_ic == cpu_len - 1);
  endtask

  task automatic cpu_reset(input int len);
    cpu_pc = '0; cpu_ic = 0; cpu_len = len;
    cpu_drive();
  endtask

  task automatic cpu_update();
    if (last_run) begin
      if (cpu_ic == cpu_len - 1) begin
        cpu_pc = cpu_pc + 1'b1;
        cpu_ic = 0;
        if (rand_len) cpu_len = $urandom_range(1, 4);
      end else begin
        cpu_ic++;
      end
    end
    cpu_drive();
  endtask

  // One clock cycle: compare at negedge, advance model at posedge, then move the CPU.
  // Returns at posedge+2 so callers may check settled outputs and set new inputs.
  task automatic run_cycle();
    @(negedge clock);
    if (reset) begin
      chk("run",         32'(bus.run),         32'(m_run()));
      chk("state",       32'(bus.state),       32'(m_st));
      chk("halt_cause",  32'(bus.halt_cause),  32'(m_cause));
      chk("cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
      if (bus.run) run_hi++;
    end
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    #1;
    cpu_update();
    #1;
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.step = 0; bus.clear = 0;
    bus.bp_addr = '0; bus.bp_valid = 0; bus.cycle_limit = '0;
    cpu_reset(1);
    model_reset();
    repeat (2) run_cycle();
    reset = 1'b1;
    run_cycle();

    // Reset state
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_run",   32'(bus.run), 0);
    chk("rst_cause", 32'(bus.halt_cause), 0);
    chk("rst_count", 32'(bus.cycle_count), 0);

    // Start / stop: exactly 10 run cycles
    run_hi = 0;
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (9) run_cycle();
    bus.stop = 1; run_cycle(); bus.stop = 0;
    repeat (3) run_cycle();
    chk("ss_run_cycles", 32'(run_hi), 10);
    chk("ss_count", 32'(bus.cycle_count), 10);
    chk("ss_state", 32'(bus.state), 3);
    chk("ss_cause", 32'(bus.halt_cause), 1);

    // Step over a 3-cycle instruction with step held
    bus.clear = 1; run_cycle(); bus.clear = 0;
    chk("clr_count", 32'(bus.cycle_count), 0);
    cpu_reset(3);
    run_hi = 0;
    bus.step = 1; repeat (20) run_cycle(); bus.step = 0;
    run_cycle();
    chk("step_run_cycles", 32'(run_hi), 3);
    chk("step_state", 32'(bus.state), 3);
    chk("step_cause", 32'(bus.halt_cause), 0);
    chk("step_count", 32'(bus.cycle_count), 3);

    // stop together with instr_done during STEP
    bus.step = 1; run_cycle(); bus.step = 0;
    run_cycle(); run_cycle();
    bus.stop = 1; run_cycle(); bus.stop = 0;
    run_cycle();
    chk("prio_state", 32'(bus.state), 3);
    chk("prio_cause", 32'(bus.halt_cause), 1);
    chk("prio_count", 32'(bus.cycle_count), 6);

    // clear during RUN
    cpu_reset(1);
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (5) run_cycle();
    bus.clear = 1; run_cycle(); bus.clear = 0;
    chk("clrrun_state", 32'(bus.state), 0);
    chk("clrrun_count", 32'(bus.cycle_count), 0);
    chk("clrrun_run",   32'(bus.run), 0);

    // Cycle budget of 7
    bus.cycle_limit = 8'd7;
    run_hi = 0;
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (20) run_cycle();
    chk("lim_count", 32'(bus.cycle_count), 7);
    chk("lim_cause", 32'(bus.halt_cause), 3);
    chk("lim_state", 32'(bus.state), 3);
    chk("lim_run_cycles", 32'(run_hi), 7);

    // Unlimited budget, counter saturates
    bus.cycle_limit = '0;
    bus.clear = 1; run_cycle(); bus.clear = 0;
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (300) run_cycle();
    chk("nolim_state", 32'(bus.state), 1);
    chk("sat_count", 32'(bus.cycle_count), CMAX);
    bus.stop = 1; run_cycle(); bus.stop = 0;
    run_cycle();
    chk("sat_hold", 32'(bus.cycle_count), CMAX);

    // Breakpoint at PC 5
    bus.clear = 1; run_cycle(); bus.clear = 0;
    cpu_reset(1);
    bus.bp_addr = 6'd5; bus.bp_valid = 1;
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (15) run_cycle();
`ifdef I281_RUN_CTRL_BREAKPOINT_EN
    chk("bp_state", 32'(bus.state), 3);
    chk("bp_cause", 32'(bus.halt_cause), 2);
    chk("bp_pc", 32'(cpu_pc), 5);
    chk("bp_count", 32'(bus.cycle_count), 5);
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (3) run_cycle();
    chk("bp_resume_state", 32'(bus.state), 1);
    chk("bp_resume_pc", 32'(cpu_pc), 8);
    repeat (70) run_cycle();
    chk("bp_again_state", 32'(bus.state), 3);
    chk("bp_again_cause", 32'(bus.halt_cause), 2);
    chk("bp_again_pc", 32'(cpu_pc), 5);
`else
    chk("nobp_state", 32'(bus.state), 1);
    chk("nobp_cause", 32'(bus.halt_cause), 0);
    chk("nobp_count", 32'(bus.cycle_count), 15);
    chk("nobp_pc", 32'(cpu_pc), 15);
`endif
    bus.bp_valid = 0;
    bus.stop = 1; run_cycle(); bus.stop = 0;

    // Asynchronous reset while running
    bus.clear = 1; run_cycle(); bus.clear = 0;
    bus.start = 1; run_cycle(); bus.start = 0;
    repeat (3) run_cycle();
    reset = 1'b0;
    #1;
    chk("arst_run",   32'(bus.run), 0);
    chk("arst_count", 32'(bus.cycle_count), 0);
    chk("arst_state", 32'(bus.state), 0);
    run_cycle();
    reset = 1'b1;
    run_cycle();

    // Random traffic against the model
    rand_len = 1;
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop  = ($urandom_range(0, 29) == 0);
      bus.clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) bus.step = ~bus.step;
      if ($urandom_range(0, 49) == 0) bus.bp_valid = ~bus.bp_valid;
      if ($urandom_range(0, 99) == 0) bus.bp_addr = PC_W'($urandom);
      if ($urandom_range(0, 199) == 0) bus.cycle_limit = CNT_W'($urandom_range(0, 40));
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i281_run_ctrl.md
# i281_run_ctrl

Run/step sequencer for the i281 multicycle CPU. It generates the single `run` enable shared by the code memory, registers, flags, data memory and program counter. It supports free-run, single-instruction step, PC breakpoint and cycle-budget halts. It sits between the board pushbuttons/switches and the `run` input of `i281_toplevel`.

## Interface
- PC_W, 6, program-counter width (matches the 64-entry code memory)
- CNT_W, 16, cycle counter and limit width
- `clock` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low; resets this block only
- `start` in 1: level; request free run
- `stop` in 1: level; request halt
- `step` in 1: raw pushbuttons level; rising edge requests one instruction
- `clear` in 1: level; return to IDLE and zero counter
- `instr_done` in 1: pulse from the CPU when an instruction completes (PC write / multicycle next-instruction trigger)
- `pc` in PC_W: current PC from the program counter
- `bp_addr` in PC_W: breakpoint address
- `bp_valid` in 1: breakpoint armed
- `cycle_limit` in CNT_W: run-cycle budget; 0 = unlimited
- `run` out 1: CPU enable
- `state` out 2: 0 IDLE, 1 RUN, 2 STEP, 3 HALT
- `halt_cause` out 2: 0 step done/none, 1 stop, 2 breakpoint, 3 limit
- `cycle_count` out CNT_W: number of cycles with `run`=1

## Operation
- FSM states: IDLE, RUN, STEP, HALT.
- `step_pulse` = `step` & ~`step_q`, where `step_q` is `step` registered.
- `bp_hit` = `bp_valid` & (`pc`==`bp_addr`) & ~`skip_q` & state∈{RUN,STEP}.
- `run` is combinational: state∈{RUN,STEP} & ~`bp_hit`. The instruction at `bp_addr` never executes while the breakpoint is active.
- `skip_q` is set on every entry to RUN/STEP and cleared after the first cycle in RUN/STEP. Resuming at the breakpoint PC therefore executes that instruction once.
- Transition priority, highest first: `clear` → IDLE, cause 0, count 0. Then `stop` (in RUN/STEP) → HALT, cause 1. Then `bp_hit` → HALT, cause 2. Then limit reached → HALT, cause 3. Then STEP & `instr_done` & `run` → HALT, cause 0. Then `start` (in IDLE/HALT) → RUN. Then `step_pulse` (in IDLE/HALT) → STEP.
- `stop` in IDLE/HALT: no effect.
- `start` and `step_pulse` in RUN/STEP: ignored.
- Counter: increments on each edge where `run`=1. It saturates at all-ones. It is cleared only by `clear` or reset; it is not cleared on start/step.
- Limit reached: `cycle_limit`≠0 & `run`=1 & `cycle_count`+1 ≥ `cycle_limit`. This yields exactly `cycle_limit` run cycles, counted from zero.
- Entering RUN/STEP writes `halt_cause`=0.

## Timing
- Reset values: state IDLE, `run`=0, `halt_cause`=0, `cycle_count`=0, `step_q`=0, `skip_q`=0.
- `start` sampled at edge N → state RUN after N → `run`=1 during cycle N+1.
- Step: the instruction executes for all of its cycles, including multicycle ones. `run` drops in the cycle after the edge that samples `instr_done`.
- `stop` sampled at edge N → `run`=0 from cycle N+1. The cycle ending at edge N still counts if `run`=1.
- Breakpoint: `run` falls in the same cycle that `pc` equals `bp_addr`, with zero latency. HALT is registered at the next edge.
- Simultaneous events:
  - `stop` + `instr_done` → cause 1.
  - `bp_hit` + limit → cause 2. Because `run`=0 in that cycle, no count occurs and the limit is not reached.
  - `start` + `step_pulse` → RUN.
  - `clear` + anything → IDLE.
- Reset mid-RUN: `run`=0 immediately (asynchronous), and the counter is lost.
- A held `step` produces one step only; a new rising edge is required.

## Configuration
- `I281_RUN_CTRL_BREAKPOINT_EN` defined: breakpoint compare, `skip_q` and cause 2 are present.
- Undefined: `bp_hit` is tied to 0, `bp_addr`/`bp_valid` are unused, and `halt_cause` never equals 2.

## Structure
- Shared package `i281_pkg` holds:
  - state encodings `RC_IDLE`/`RC_RUN`/`RC_STEP`/`RC_HALT`
  - cause encodings `HC_NONE`/`HC_STOP`/`HC_BP`/`HC_LIMIT`
  - default widths
- One sub-module, `i281_edge_detect`: registered rising-edge detector for `step`, reusable for other pushbuttons.
- Everything else (FSM, counter, compare) lives in `i281_run_ctrl`.

## Test plan
- Start/stop: reset, `start` pulse, 10 cycles, `stop` → `run` high for exactly 10 cycles; `cycle_count`=10; state HALT; cause 1.
- Step over a multicycle instruction: `instr_done` 3 cycles after `step` edge, `step` held 20 cycles → `run` high 3 cycles; one step only; state HALT; cause 0.
- Breakpoint: `bp_addr`=5, `bp_valid`=1, PC counts 0,1,2… → `run`=0 when `pc`=5; cause 2. `start` again → instruction 5 executes; a later return to PC 5 halts again.
- Limit: `cycle_limit`=7, `start` → `cycle_count`=7; cause 3; `run` low from cycle 8. `cycle_limit`=0 → no limit halt.
- Priority: `stop` and `instr_done` in the same cycle during STEP → cause 1. `clear` during RUN → IDLE, count 0.
- Config: build without `I281_RUN_CTRL_BREAKPOINT_EN`, PC passes `bp_addr` → no halt; cause never 2.
